// File: rtl/key_event_conditioner.sv
// key_event_conditioner
//
// Per-button conditioner for raw, already active-high push-button pins.
// Each key is synchronized, debounced against a shared 1 ms tick, and turned
// into a clean level plus single-cycle press/release events. A key held long
// enough raises a long-press level and then produces typematic auto-repeat
// press events. All keys share the tick prescaler. Everything else is per key.
//
// Ports:
//   clk           in   1       system clock
//   rst           in   1       asynchronous, active-high reset
//   key_raw       in   w_key   raw keys (asynchronous, active-high)
//   key_stable    out  w_key   debounced level
//   key_pressed   out  w_key   1-cycle pulse on debounced press and each auto-repeat
//   key_released  out  w_key   1-cycle pulse on debounced release
//   key_long      out  w_key   high from the long-press point until release
//   key_state_dbg out  2*w_key per-key FSM state, key k in bits [2k+1:2k]
//
// All outputs are registered and reset to 0.
module key_event_conditioner #(
    parameter int clk_mhz       = 27,
    parameter int w_key         = 2,
    parameter int cycles_per_ms = clk_mhz * 1000,
    parameter int debounce_ms   = 10,
    parameter int hold_ms       = 500,
    parameter int repeat_ms     = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [w_key-1:0]   key_raw,
    output logic [w_key-1:0]   key_stable,
    output logic [w_key-1:0]   key_pressed,
    output logic [w_key-1:0]   key_released,
    output logic [w_key-1:0]   key_long,
    output logic [2*w_key-1:0] key_state_dbg
);

    // Counter widths are clamped to at least 1 bit so degenerate settings
    // (one cycle per tick, repeat disabled) still elaborate.
    localparam int CNT_W  = (cycles_per_ms > 1) ? $clog2(cycles_per_ms) : 1;
    localparam int DB_W   = (debounce_ms > 0) ? $clog2(debounce_ms + 1) : 1;
    localparam int HOLD_W = (hold_ms > 0) ? $clog2(hold_ms + 1) : 1;
    localparam int REP_W  = (repeat_ms > 0) ? $clog2(repeat_ms + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(cycles_per_ms - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [DB_W-1:0]   DB_TARGET   = DB_W'(debounce_ms);
    localparam logic [DB_W-1:0]   DB_ONE      = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_TARGET = HOLD_W'(hold_ms);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
    localparam logic [REP_W-1:0]  REP_TARGET  = REP_W'(repeat_ms);
    localparam logic [REP_W-1:0]  REP_ONE     = REP_W'(1);
    localparam bit                REP_EN      = (repeat_ms > 0);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_HELD     = 2'd1,
        ST_REPEAT   = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Shared 1 ms tick prescaler
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             tick;

    assign tick    = (presc_q == CNT_LAST);
    assign presc_d = tick ? '0 : presc_q + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc_q <= '0;
        else     presc_q <= presc_d;
    end

    // ------------------------------------------------------------------
    // Per-key logic
    // ------------------------------------------------------------------
    for (genvar k = 0; k < w_key; k++) begin : g_key
        logic [1:0]        sync_q;
        logic              sync;
        logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
        logic              stable_q, stable_d;
        logic              db_rise, db_fall;
        state_e            state_q, state_d;
        logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
        logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
        logic              long_fire, rep_fire;
        logic              pressed_q, pressed_d;
        logic              released_q, released_d;
        logic              long_q, long_d;

        // Two-flop synchronizer; sync_q[1] is the synchronized key.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) sync_q <= '0;
            else     sync_q <= {sync_q[0], key_raw[k]};
        end
        assign sync = sync_q[1];

        // Debounce: any agreement with the stable level restarts the count,
        // so only debounce_ms consecutive disagreeing ticks flip the level.
        always_comb begin
            db_cnt_d = db_cnt_q;
            stable_d = stable_q;
            db_rise  = 1'b0;
            db_fall  = 1'b0;
            if (sync == stable_q) begin
                db_cnt_d = '0;
            end else if (tick) begin
                if (db_cnt_q + DB_ONE == DB_TARGET) begin
                    stable_d = sync;
                    db_cnt_d = '0;
                    db_rise  = sync;
                    db_fall  = ~sync;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                db_cnt_q <= '0;
                stable_q <= 1'b0;
            end else begin
                db_cnt_q <= db_cnt_d;
                stable_q <= stable_d;
            end
        end

        // FSM state register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= ST_RELEASED;
                hold_cnt_q <= '0;
                rep_cnt_q  <= '0;
            end else begin
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
                rep_cnt_q  <= rep_cnt_d;
            end
        end

        // FSM next state. A debounced release is checked first so that a
        // long-press or repeat pulse due in the release cycle is dropped.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            rep_cnt_d  = rep_cnt_q;
            long_fire  = 1'b0;
            rep_fire   = 1'b0;
            case (state_q)
                ST_RELEASED: begin
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                    if (db_rise) state_d = ST_HELD;
                end
                ST_HELD: begin
                    if (db_fall) begin
                        state_d    = ST_RELEASED;
                        hold_cnt_d = '0;
                    end else if (tick) begin
                        if (hold_cnt_q + HOLD_ONE == HOLD_TARGET) begin
                            state_d    = ST_REPEAT;
                            hold_cnt_d = '0;
                            rep_cnt_d  = '0;
                            long_fire  = 1'b1;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_ONE;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (db_fall) begin
                        state_d   = ST_RELEASED;
                        rep_cnt_d = '0;
                    end else if (tick && REP_EN) begin
                        if (rep_cnt_q + REP_ONE == REP_TARGET) begin
                            rep_cnt_d = '0;
                            rep_fire  = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_ONE;
                        end
                    end
                end
                default: begin
                    state_d    = ST_RELEASED;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end
            endcase
        end

        // FSM outputs (registered below). key_long is simply "in REPEAT",
        // so it drops on the same edge that issues the release pulse.
        always_comb begin
            pressed_d  = db_rise | long_fire | rep_fire;
            released_d = db_fall;
            long_d     = (state_d == ST_REPEAT);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
                long_q     <= 1'b0;
            end else begin
                pressed_q  <= pressed_d;
                released_q <= released_d;
                long_q     <= long_d;
            end
        end

        assign key_stable[k]            = stable_q;
        assign key_pressed[k]           = pressed_q;
        assign key_released[k]          = released_q;
        assign key_long[k]              = long_q;
        assign key_state_dbg[2*k +: 2]  = state_q;
    end

endmodule

// File: tb/tb_key_event_conditioner.sv
module tb_key_event_conditioner;
  localparam int W = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] raw_a = 2'b11;
  logic [W-1:0] raw_b = 2'b00;
  logic [W-1:0] stable_a, pressed_a, released_a, long_a;
  logic [W-1:0] stable_b, pressed_b, released_b, long_b;
  logic [2*W-1:0] dbg_a, dbg_b;

  key_event_conditioner #(
    .clk_mhz(27), .w_key(W), .cycles_per_ms(4), .debounce_ms(3), .hold_ms(10), .repeat_ms(4)
  ) dut_a (
    .clk(clk), .rst(rst), .key_raw(raw_a), .key_stable(stable_a), .key_pressed(pressed_a),
    .key_released(released_a), .key_long(long_a), .key_state_dbg(dbg_a)
  );

  key_event_conditioner #(
    .clk_mhz(27), .w_key(W), .cycles_per_ms(4), .debounce_ms(3), .hold_ms(10), .repeat_ms(0)
  ) dut_b (
    .clk(clk), .rst(rst), .key_raw(raw_b), .key_stable(stable_b), .key_pressed(pressed_b),
    .key_released(released_b), .key_long(long_b), .key_state_dbg(dbg_b)
  );

  // cycle counter: value seen at a negedge = number of posedges so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // output event log, written only by this monitor
  int p0_q[$], p1_q[$], r0_q[$], r1_q[$], pb0_q[$], pb1_q[$];
  int long_rise_a0 = -1;
  int long_fall_a0 = -1;
  int long_cyc_a0 = 0;
  logic long_prev_a0 = 1'b0;

  always @(negedge clk) begin
    if (pressed_a[0]) p0_q.push_back(cyc);
    if (pressed_a[1]) p1_q.push_back(cyc);
    if (released_a[0]) r0_q.push_back(cyc);
    if (released_a[1]) r1_q.push_back(cyc);
    if (pressed_b[0]) pb0_q.push_back(cyc);
    if (pressed_b[1]) pb1_q.push_back(cyc);
    if (long_a[0] && !long_prev_a0) long_rise_a0 = cyc;
    if (!long_a[0] && long_prev_a0) long_fall_a0 = cyc;
    if (long_a[0]) long_cyc_a0 = long_cyc_a0 + 1;
    long_prev_a0 = long_a[0];
  end

  // driver / checker tasks; the main flow acts 1 unit after each negedge
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_a(input string tag, input int k, input logic lvl, input int max_c,
                        output int at_c);
    int found;
    found = 0;
    at_c = -1;
    for (int i = 0; i < max_c && found == 0; i++) begin
      step();
      if (stable_a[k] === lvl) begin
        found = 1;
        at_c = cyc;
      end
    end
    check(tag, found, 1);
  endtask

  task automatic wait_b(input string tag, input logic [W-1:0] lvl, input int max_c,
                        output int at_c);
    int found;
    found = 0;
    at_c = -1;
    for (int i = 0; i < max_c && found == 0; i++) begin
      step();
      if (stable_b === lvl) begin
        found = 1;
        at_c = cyc;
      end
    end
    check(tag, found, 1);
  endtask

  initial begin
    int t, s, f, n0, n1, nr, lc, found;

    // ---- reset with both keys pressed ----
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_out_a", {stable_a, pressed_a, released_a, long_a}, 0);
      check("rst_out_b", {stable_b, pressed_b, released_b, long_b}, 0);
    end
    rst = 1'b0;
    t = cyc;
    wait_a("rst_wait", 0, 1'b1, 30, s);
    check("rst_stable1", stable_a[1], 1);
    check_range("rst_lat", s - t, 11, 14);
    steps(2);
    check("rst_p0_cnt", p0_q.size(), 1);
    check("rst_p1_cnt", p1_q.size(), 1);
    if (p0_q.size() > 0) check("rst_p0_at", p0_q[0], s);
    if (p1_q.size() > 0) check("rst_p1_at", p1_q[0], s);

    // ---- release after 20 cycles held ----
    steps(18);
    lc = long_cyc_a0;
    nr = r0_q.size();
    raw_a = 2'b00;
    t = cyc;
    wait_a("rel_wait", 0, 1'b0, 30, f);
    check_range("rel_lat", f - t, 11, 14);
    steps(2);
    check("rel_cnt", r0_q.size() - nr, 1);
    if (r0_q.size() > nr) check("rel_at", r0_q[nr], f);
    check("rel_no_long", long_cyc_a0 - lc, 0);
    steps(5);

    // ---- bounce rejection ----
    n0 = p0_q.size();
    nr = r0_q.size();
    for (int i = 0; i < 20; i++) begin
      raw_a[0] = ~raw_a[0];
      steps(2);
    end
    check("bnc_no_press", p0_q.size() - n0, 0);
    check("bnc_no_rel", r0_q.size() - nr, 0);
    raw_a[0] = 1'b1;
    t = cyc;
    wait_a("bnc_wait", 0, 1'b1, 30, s);
    check_range("bnc_lat", s - t, 11, 14);
    steps(5);
    check("bnc_press_cnt", p0_q.size() - n0, 1);
    if (p0_q.size() > n0) check("bnc_press_at", p0_q[n0], s);
    raw_a[0] = 1'b0;
    wait_a("bnc_rel_wait", 0, 1'b0, 30, f);
    steps(5);

    // ---- long press and repeat: raw held 114 cycles ----
    n0 = p0_q.size();
    nr = r0_q.size();
    raw_a[0] = 1'b1;
    t = cyc;
    wait_a("lp_wait", 0, 1'b1, 30, s);
    exp_q.push_back(s);
    exp_q.push_back(s + 40);
    exp_q.push_back(s + 56);
    exp_q.push_back(s + 72);
    exp_q.push_back(s + 88);
    exp_q.push_back(s + 104);
    steps(114 - (cyc - t));
    raw_a[0] = 1'b0;
    wait_a("lp_rel_wait", 0, 1'b0, 30, f);
    steps(3);
    check("lp_long_rise", long_rise_a0, s + 40);
    check("lp_long_fall", long_fall_a0, f);
    check("lp_rel_cnt", r0_q.size() - nr, 1);
    if (r0_q.size() > nr) check("lp_rel_at", r0_q[nr], f);
    check("lp_press_cnt", p0_q.size() - n0, 6);
    for (int i = n0; i < p0_q.size(); i++) begin
      if (exp_q.size() > 0) check("lp_press_at", p0_q[i], int'(exp_q.pop_front()));
    end
    check("lp_exp_left", exp_q.size(), 0);
    exp_q.delete();
    steps(5);

    // ---- simultaneous keys, repeat disabled ----
    n0 = pb0_q.size();
    n1 = pb1_q.size();
    raw_b = 2'b11;
    wait_b("sim_wait", 2'b11, 30, s);
    exp_q.push_back(s);
    exp_q.push_back(s + 40);
    steps(240 - (cyc - s));
    check("sim_long", long_b, 2'b11);
    raw_b = 2'b00;
    wait_b("sim_rel_wait", 2'b00, 40, f);
    steps(3);
    check("sim_cnt0", pb0_q.size() - n0, 2);
    check("sim_cnt1", pb1_q.size() - n1, 2);
    for (int i = 0; i < 2; i++) begin
      if (exp_q.size() > 0 && pb0_q.size() > n0 + i && pb1_q.size() > n1 + i) begin
        lc = int'(exp_q.pop_front());
        check("sim_p0_at", pb0_q[n0 + i], lc);
        check("sim_p1_at", pb1_q[n1 + i], lc);
      end
    end
    exp_q.delete();

    // ---- reset while key 1 is in REPEAT ----
    raw_a[1] = 1'b1;
    found = 0;
    for (int i = 0; i < 80 && found == 0; i++) begin
      step();
      if (long_a[1] === 1'b1) found = 1;
    end
    check("mid_reach_long", found, 1);
    steps(10);
    check("mid_pre_stable1", stable_a[1], 1);
    nr = r1_q.size();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_stable1", stable_a[1], 0);
    check("mid_long1", long_a[1], 0);
    steps(3);
    rst = 1'b0;
    t = cyc;
    n1 = p1_q.size();
    wait_a("mid_wait", 1, 1'b1, 30, s);
    check_range("mid_lat", s - t, 11, 14);
    steps(3);
    check("mid_no_rel", r1_q.size() - nr, 0);
    check("mid_press_cnt", p1_q.size() - n1, 1);
    raw_a = 2'b00;
    steps(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
